// File: rtl/decode_issue_buffer_if.sv
// Fetch / decoder / issue / writeback bundle for the decode issue buffer.
// The buffer takes the slave side; fetch, decoder, execute and writeback together form the master.
interface decode_issue_buffer_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            flush;
  logic            f_valid;
  logic            f_ready;
  logic [XLEN-1:0] f_pc;
  logic [31:0]     f_instr;
  logic            f_exc;
  logic [3:0]      f_ecause;
  logic [31:0]     dec_instr;
  logic            dec_valid;
  logic            dec_wren;
  logic            dec_rden1;
  logic            dec_rden2;
  logic            dec_multicycle;
  logic [4:0]      dec_waddr;
  logic [4:0]      dec_raddr1;
  logic [4:0]      dec_raddr2;
  logic            i_valid;
  logic            i_ready;
  logic [XLEN-1:0] i_pc;
  logic [XLEN-1:0] i_npc;
  logic [31:0]     i_instr;
  logic            i_exc;
  logic [3:0]      i_ecause;
  logic            wb_valid;
  logic [4:0]      wb_waddr;
  logic [CW-1:0]   count;

  modport master (
    output flush, f_valid, f_pc, f_instr, f_exc, f_ecause,
    output dec_valid, dec_wren, dec_rden1, dec_rden2, dec_multicycle,
    output dec_waddr, dec_raddr1, dec_raddr2,
    output i_ready, wb_valid, wb_waddr,
    input  f_ready, dec_instr, i_valid, i_pc, i_npc, i_instr, i_exc, i_ecause, count
  );

  modport slave (
    input  flush, f_valid, f_pc, f_instr, f_exc, f_ecause,
    input  dec_valid, dec_wren, dec_rden1, dec_rden2, dec_multicycle,
    input  dec_waddr, dec_raddr1, dec_raddr2,
    input  i_ready, wb_valid, wb_waddr,
    output f_ready, dec_instr, i_valid, i_pc, i_npc, i_instr, i_exc, i_ecause, count
  );
endinterface

// File: rtl/decode_issue_buffer.sv
// In-order instruction FIFO between fetch and execute with a per-register busy scoreboard
// that holds back the head on RAW/WAW hazards against outstanding multi-cycle results.
module decode_issue_buffer #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int NREG  = 32
) (
  input logic                 clk,
  input logic                 rst,
  decode_issue_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [XLEN-1:0] pc_mem     [DEPTH];
  logic [31:0]     instr_mem  [DEPTH];
  logic            exc_mem    [DEPTH];
  logic [3:0]      ecause_mem [DEPTH];

  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   cnt;
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;

  logic            empty;
  logic            hazard;
  logic            exc_raw;
  logic            push;
  logic            pop;
  logic            sb_set;
  logic [31:0]     head_instr;
  logic [XLEN-1:0] head_pc;

  // Head view: decoder feed, hazard check and issue outputs all come from the FIFO head
  always_comb begin
    empty      = (cnt == '0);
    head_instr = instr_mem[rd_ptr];
    head_pc    = pc_mem[rd_ptr];
    hazard     = (bus.dec_rden1 & busy[bus.dec_raddr1]) |
                 (bus.dec_rden2 & busy[bus.dec_raddr2]) |
                 (bus.dec_wren  & busy[bus.dec_waddr]);
    exc_raw    = ~empty & (exc_mem[rd_ptr] | ~bus.dec_valid);

    bus.dec_instr = empty ? '0 : head_instr;
    bus.i_instr   = empty ? '0 : head_instr;
    bus.i_pc      = head_pc;
    bus.i_npc     = head_pc + ((head_instr[1:0] == 2'b11) ? XLEN'(4) : XLEN'(2));
    bus.i_exc     = exc_raw;
    // A fetch fault outranks an illegal decode for the reported cause
    bus.i_ecause  = exc_mem[rd_ptr] ? ecause_mem[rd_ptr] : 4'd2;
    bus.i_valid   = ~empty & (exc_raw | ~hazard) & ~bus.flush;
    bus.f_ready   = (cnt < FULL);
    bus.count     = cnt;

    push   = bus.f_valid & bus.f_ready & ~bus.flush;
    pop    = bus.i_valid & bus.i_ready;
    sb_set = pop & ~exc_raw & bus.dec_wren & bus.dec_multicycle & (bus.dec_waddr != 5'd0);

    // Set is applied after clear so a same-cycle issue to the written-back register keeps it busy
    busy_nxt = busy;
    if (bus.wb_valid) busy_nxt[bus.wb_waddr] = 1'b0;
    if (sb_set)       busy_nxt[bus.dec_waddr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Entry storage: data only, never reset
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]     <= bus.f_pc;
      instr_mem[wr_ptr]  <= bus.f_instr;
      exc_mem[wr_ptr]    <= bus.f_exc;
      ecause_mem[wr_ptr] <= bus.f_ecause;
    end
  end

  // Control state: flush empties the FIFO but leaves the scoreboard tracking in-flight ops
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      busy   <= '0;
    end else begin
      busy <= busy_nxt;
      if (bus.flush) begin
        cnt    <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        case ({push, pop})
          2'b10:   cnt <= cnt + CW'(1);
          2'b01:   cnt <= cnt - CW'(1);
          default: cnt <= cnt;
        endcase
      end
    end
  end
endmodule
